// File: rtl/controle_coprocessador_if.sv
// Host/unit-side bundle of the 5x5 int8 matrix coprocessor sequencer.
// master: host and operation units; slave: controle_coprocessador.
interface controle_coprocessador_if;
    localparam int unsigned MAT_W  = 200;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned UNIT_N = 8;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_op;
    logic [MAT_W-1:0]  matrizA_in;
    logic [MAT_W-1:0]  matrizB_in;
    logic [MAT_W-1:0]  op_matrizA;
    logic [MAT_W-1:0]  op_matrizB;
    logic [UNIT_N-1:0] start_op;
    logic [OP_W-1:0]   op_sel;
    logic [UNIT_N-1:0] done_op;
    logic [MAT_W-1:0]  result_in;
    logic [MAT_W-1:0]  result_out;
    logic              result_valid;
    logic              busy;
    logic              error;

    modport master (
        output cmd_valid, cmd_op, matrizA_in, matrizB_in, done_op, result_in,
        input  cmd_ready, op_matrizA, op_matrizB, start_op, op_sel,
               result_out, result_valid, busy, error
    );

    modport slave (
        input  cmd_valid, cmd_op, matrizA_in, matrizB_in, done_op, result_in,
        output cmd_ready, op_matrizA, op_matrizB, start_op, op_sel,
               result_out, result_valid, busy, error
    );
endinterface

// File: rtl/controle_coprocessador.sv
// Sequencer for the 5x5 int8 matrix coprocessor: accepts one command, latches
// operands, runs exactly one operation unit, captures its result and reports
// done/error. Optional macro OP_TIMEOUT_EN aborts a handshaked unit that never
// answers within TIMEOUT cycles.
module controle_coprocessador #(
    parameter logic [7:0]  COMB_MASK = 8'h30,
    parameter int unsigned COMB_LAT  = 1,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                    clk,
    input  logic                    reset_n,
    controle_coprocessador_if.slave bus
);
    localparam int unsigned MAT_W  = 200;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned UNIT_N = 8;
    localparam int unsigned CNT_W  = 8;
    localparam logic [OP_W-1:0] OP_RESERVED = OP_W'(7);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_CAPTURE,
        ST_FAULT
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic [MAT_W-1:0]   a_q, a_d;
    logic [MAT_W-1:0]   b_q, b_d;
    logic [UNIT_N-1:0]  start_q, start_d;
    logic [MAT_W-1:0]   res_q, res_d;
    logic               rv_q, rv_d;
    logic               err_q, err_d;

    logic unit_comb;
    logic unit_done;
    logic comb_due;
    logic timeout_hit;

    // Per-unit completion conditions for the currently latched opcode
    assign unit_comb = COMB_MASK[op_q];
    assign unit_done = bus.done_op[op_q];
    assign comb_due  = (cnt_q == CNT_W'(COMB_LAT - 1));

`ifdef OP_TIMEOUT_EN
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign timeout_hit    = 1'b0;
    assign unused_timeout = |CNT_W'(TIMEOUT);
`endif

    // State and output registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            start_q <= '0;
            res_q   <= '0;
            rv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            start_q <= start_d;
            res_q   <= res_d;
            rv_q    <= rv_d;
            err_q   <= err_d;
        end
    end

    // Next state plus next values of the registered outputs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        start_d = start_q;
        res_d   = res_q;
        rv_d    = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    op_d  = bus.cmd_op;
                    a_d   = bus.matrizA_in;
                    b_d   = bus.matrizB_in;
                    cnt_d = '0;
                    if (bus.cmd_op == OP_RESERVED) begin
                        state_d = ST_FAULT;
                        start_d = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        start_d = UNIT_N'(1) << bus.cmd_op;
                    end
                end
            end

            ST_RUN: begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (unit_comb ? comb_due : unit_done) begin
                    // Result is sampled while op_sel still steers the unit mux
                    state_d = ST_CAPTURE;
                    start_d = '0;
                    res_d   = bus.result_in;
                    rv_d    = 1'b1;
                end else if (!unit_comb && timeout_hit) begin
                    state_d = ST_FAULT;
                    start_d = '0;
                    err_d   = 1'b1;
                end
            end

            ST_CAPTURE: begin
                state_d = ST_IDLE;
            end

            ST_FAULT: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                start_d = '0;
            end
        endcase
    end

    // Port drive; ready/busy are direct decodes of the state register
    assign bus.cmd_ready    = (state_q == ST_IDLE);
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.op_matrizA   = a_q;
    assign bus.op_matrizB   = b_q;
    assign bus.start_op     = start_q;
    assign bus.op_sel       = op_q;
    assign bus.result_out   = res_q;
    assign bus.result_valid = rv_q;
    assign bus.error        = err_q;

endmodule

// File: tb/tb_controle_coprocessador.sv
// Randomized self-checking bench for controle_coprocessador: per-command
// timing/result expectations derived from the command rules, with stand-in
// operation units driving result_in and done_op.
module tb_controle_coprocessador;
    localparam logic [7:0]  COMB_MASK_TB = 8'h30;
    localparam int unsigned COMB_LAT_TB  = 1;
    localparam int unsigned TIMEOUT_TB   = 8;

    logic clk;
    logic reset_n;
    int   n_vec;
    int   n_err;

    controle_coprocessador_if bus ();

    controle_coprocessador #(
        .COMB_MASK (COMB_MASK_TB),
        .COMB_LAT  (COMB_LAT_TB),
        .TIMEOUT   (TIMEOUT_TB)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in operation units on the int8 5x5 matrices
    function automatic logic [199:0] unit_fn(input logic [2:0] op,
                                             input logic [199:0] a,
                                             input logic [199:0] b);
        logic [199:0] r;
        logic [7:0]   acc;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
                case (op)
                    3'd0: r[40*i+8*j +: 8] = a[40*i+8*j +: 8] + b[40*i+8*j +: 8];
                    3'd1: r[40*i+8*j +: 8] = a[40*i+8*j +: 8] - b[40*i+8*j +: 8];
                    3'd2: begin
                        acc = 8'h00;
                        for (int k = 0; k < 5; k++)
                            acc = acc + 8'(a[40*i+8*k +: 8] * b[40*k+8*j +: 8]);
                        r[40*i+8*j +: 8] = acc;
                    end
                    3'd3: r[40*i+8*j +: 8] = 8'(a[40*i+8*j +: 8] * b[7:0]);
                    3'd4: r[40*i+8*j +: 8] = a[40*j+8*i +: 8];
                    3'd5: r[40*i+8*j +: 8] = 8'h00 - a[40*i+8*j +: 8];
                    3'd6: r[40*i+8*j +: 8] = a[40*i+8*j +: 8] ^ b[40*i+8*j +: 8];
                    default: r[40*i+8*j +: 8] = 8'h00;
                endcase
            end
        end
        return r;
    endfunction

    // External result mux; a handshaked unit shows garbage until its done
    always_comb begin
        bus.result_in = unit_fn(bus.op_sel, bus.op_matrizA, bus.op_matrizB);
        if (!COMB_MASK_TB[bus.op_sel] && !bus.done_op[bus.op_sel])
            bus.result_in = ~bus.result_in;
    end

    task automatic check_eq(input string tag, input logic [199:0] got, input logic [199:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [199:0] rand_mat();
        logic [199:0] m;
        for (int i = 0; i < 7; i++)
            m[32*i +: 32] = (i == 6) ? {24'h0, 8'($urandom)} : $urandom;
        return m;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_start"},  200'(bus.start_op), 200'(0));
        check_eq({tag, "_opsel"},  200'(bus.op_sel), 200'(0));
        check_eq({tag, "_opA"},    bus.op_matrizA, 200'(0));
        check_eq({tag, "_opB"},    bus.op_matrizB, 200'(0));
        check_eq({tag, "_res"},    bus.result_out, 200'(0));
        check_eq({tag, "_rv"},     200'(bus.result_valid), 200'(0));
        check_eq({tag, "_err"},    200'(bus.error), 200'(0));
        check_eq({tag, "_busy"},   200'(bus.busy), 200'(0));
        check_eq({tag, "_ready"},  200'(bus.cmd_ready), 200'(1));
    endtask

    // Wait (bounded) for cmd_ready, then present a command for one accept edge
    task automatic present_cmd(input logic [2:0] op, input logic [199:0] a, input logic [199:0] b);
        int budget;
        budget = 0;
        while (!bus.cmd_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        check_eq("ready_wait", 200'(bus.cmd_ready), 200'(1));
        bus.cmd_valid  = 1'b1;
        bus.cmd_op     = op;
        bus.matrizA_in = a;
        bus.matrizB_in = b;
        bus.done_op    = 8'($urandom);
    endtask

    logic [2:0]   pend_op;
    logic [199:0] pend_a, pend_b;

    // One full command; dly = cycle of RUN in which the handshaked unit answers
    task automatic do_cmd(input logic [2:0] op, input logic [199:0] a, input logic [199:0] b,
                          input int dly, input bit hold);
        logic [199:0] exp_res, prev_res;
        logic [7:0]   oh;
        logic [7:0]   dn;
        bit           comb;
        int           run_len;
        present_cmd(op, a, b);
        prev_res = bus.result_out;
        exp_res  = unit_fn(op, a, b);
        oh       = 8'h01 << op;
        comb     = COMB_MASK_TB[op];
        if (op == 3'd7) begin
            @(negedge clk);
            if (!hold) bus.cmd_valid = 1'b0;
            check_eq("rsv_err",   200'(bus.error), 200'(1));
            check_eq("rsv_start", 200'(bus.start_op), 200'(0));
            check_eq("rsv_rv",    200'(bus.result_valid), 200'(0));
            check_eq("rsv_ready", 200'(bus.cmd_ready), 200'(0));
            check_eq("rsv_res",   bus.result_out, prev_res);
            check_eq("rsv_opsel", 200'(bus.op_sel), 200'(7));
            @(negedge clk);
            check_eq("rsv_ready2", 200'(bus.cmd_ready), 200'(1));
            check_eq("rsv_err2",   200'(bus.error), 200'(0));
            check_eq("rsv_busy2",  200'(bus.busy), 200'(0));
            return;
        end
        run_len = comb ? int'(COMB_LAT_TB) : dly;
        for (int k = 1; k <= run_len; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (hold) begin
                    bus.cmd_op     = pend_op;
                    bus.matrizA_in = pend_a;
                    bus.matrizB_in = pend_b;
                end else begin
                    bus.cmd_valid = 1'b0;
                end
            end
            check_eq("run_start", 200'(bus.start_op), 200'(oh));
            check_eq("run_rv",    200'(bus.result_valid), 200'(0));
            check_eq("run_busy",  200'(bus.busy), 200'(1));
            check_eq("run_ready", 200'(bus.cmd_ready), 200'(0));
            check_eq("run_opsel", 200'(bus.op_sel), 200'(op));
            check_eq("run_opA",   bus.op_matrizA, a);
            check_eq("run_opB",   bus.op_matrizB, b);
            check_eq("run_res",   bus.result_out, prev_res);
            dn = 8'($urandom);
            if (!comb) dn[op] = (k == dly);
            bus.done_op = dn;
        end
        @(negedge clk);
        bus.done_op = 8'($urandom);
        check_eq("cap_rv",    200'(bus.result_valid), 200'(1));
        check_eq("cap_start", 200'(bus.start_op), 200'(0));
        check_eq("cap_err",   200'(bus.error), 200'(0));
        check_eq("cap_res",   bus.result_out, exp_res);
        @(negedge clk);
        check_eq("post_rv",    200'(bus.result_valid), 200'(0));
        check_eq("post_ready", 200'(bus.cmd_ready), 200'(1));
        check_eq("post_res",   bus.result_out, exp_res);
        check_eq("post_opA",   bus.op_matrizA, a);
    endtask

    initial begin
        logic [199:0] ma, mb;
        logic [2:0]   rop;
        n_vec         = 0;
        n_err         = 0;
        reset_n       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.matrizA_in = '0;
        bus.matrizB_in = '0;
        bus.done_op   = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Transposta of A[r][c] = 10r+c
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                ma[40*r+8*c +: 8] = 8'(10*r + c);
        do_cmd(3'd4, ma, rand_mat(), 0, 1'b0);

        // Soma of all-3 and all-4, done five cycles into RUN
        for (int i = 0; i < 25; i++) begin
            ma[8*i +: 8] = 8'h03;
            mb[8*i +: 8] = 8'h04;
        end
        do_cmd(3'd0, ma, mb, 5, 1'b0);
        check_eq("soma_all7", bus.result_out, {25{8'h07}});

        // Reserved opcode
        do_cmd(3'd7, rand_mat(), rand_mat(), 0, 1'b0);

        // cmd_valid held through a mult_matriz; queued soma taken after CAPTURE
        pend_op = 3'd0;
        pend_a  = rand_mat();
        pend_b  = rand_mat();
        do_cmd(3'd2, rand_mat(), rand_mat(), 4, 1'b1);
        do_cmd(pend_op, pend_a, pend_b, 2, 1'b0);

        // Random back-to-back commands
        for (int t = 0; t < 60; t++) begin
            rop = 3'($urandom_range(0, 7));
            do_cmd(rop, rand_mat(), rand_mat(), int'($urandom_range(1, 8)), 1'b0);
        end

        // Determinante unit that never answers
        ma = rand_mat();
        present_cmd(3'd6, ma, rand_mat());
`ifdef OP_TIMEOUT_EN
        for (int k = 1; k <= int'(TIMEOUT_TB); k++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            check_eq("to_start", 200'(bus.start_op), 200'(8'h40));
            check_eq("to_err",   200'(bus.error), 200'(0));
            bus.done_op = 8'($urandom) & 8'hBF;
        end
        @(negedge clk);
        check_eq("to_fault_err",   200'(bus.error), 200'(1));
        check_eq("to_fault_start", 200'(bus.start_op), 200'(0));
        check_eq("to_fault_rv",    200'(bus.result_valid), 200'(0));
        bus.done_op = 8'h40;
        @(negedge clk);
        check_eq("to_ready", 200'(bus.cmd_ready), 200'(1));
        check_eq("to_err2",  200'(bus.error), 200'(0));
        @(negedge clk);
        check_eq("to_late_rv",   200'(bus.result_valid), 200'(0));
        check_eq("to_late_busy", 200'(bus.busy), 200'(0));
        bus.done_op = 8'h00;
`else
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            bus.done_op   = 8'($urandom) & 8'hBF;
            if (k % 8 == 0) begin
                check_eq("nto_busy",  200'(bus.busy), 200'(1));
                check_eq("nto_start", 200'(bus.start_op), 200'(8'h40));
                check_eq("nto_err",   200'(bus.error), 200'(0));
            end
        end
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check_reset_outputs("nto_reset");
`endif

        // Reset in the middle of a mult_matriz run
        present_cmd(3'd2, rand_mat(), rand_mat());
        bus.done_op = 8'h00;
        repeat (3) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            bus.done_op   = 8'h00;
        end
        check_eq("mid_start", 200'(bus.start_op), 200'(8'h04));
        reset_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        reset_n     = 1'b1;
        bus.done_op = 8'h04;
        repeat (3) begin
            @(negedge clk);
            check_eq("mid_late_rv",   200'(bus.result_valid), 200'(0));
            check_eq("mid_late_err",  200'(bus.error), 200'(0));
            check_eq("mid_late_busy", 200'(bus.busy), 200'(0));
        end
        bus.done_op = 8'h00;

        // Controller still healthy afterwards
        do_cmd(3'd5, rand_mat(), rand_mat(), 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
